uart_fifo_sched: RTL and testbench

- Single-clock controller that sequences the 256x8 UART FIFO.
- Write side: accepts host bytes, issues active-low write strobes to the FIFO, and tracks its own occupancy.
- Read side: issues active-low read strobes and absorbs the FIFO's 2-cycle read latency (array read plus output register). It then presents bytes to the UART transmitter over a valid/ready handshake.
- Also raises a programmable fill-level interrupt and a sticky overflow flag. Sits between the APB/host register block and the FIFO/transmitter.

---
 rtl/uart_fifo_pkg.sv | 13 +
 rtl/uart_fifo_occ.sv | 44 ++++
 rtl/uart_fifo_sched.sv | 129 ++++++++++++
 tb/tb_uart_fifo_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART FIFO scheduler.
package uart_fifo_pkg;

    localparam int unsigned FIFO_DEPTH_C = 256;
    localparam int unsigned RD_LATENCY_C = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } rd_state_e;

endpackage

// File: rtl/uart_fifo_occ.sv
// Occupancy counter for the UART FIFO: host-full flag, write accept and fill-level interrupt.
module uart_fifo_occ #(
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned CNT_WIDTH  = 9,
    parameter int unsigned THR_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 host_we,
    input  logic                 fifo_full,
    input  logic                 rd_issue,
    input  logic [THR_WIDTH-1:0] thresh,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 thresh_irq,
    output logic                 host_full_c,
    output logic                 wr_accept_c
);

    logic [CNT_WIDTH-1:0] count_next;

    assign host_full_c = (count == CNT_WIDTH'(FIFO_DEPTH)) | fifo_full;
    assign wr_accept_c = host_we & ~host_full_c;

    // A write and a read issue in the same cycle cancel out.
    always_comb begin
        count_next = count;
        if (wr_accept_c && !rd_issue) begin
            count_next = count + CNT_WIDTH'(1);
        end else if (!wr_accept_c && rd_issue) begin
            count_next = count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count      <= '0;
            thresh_irq <= 1'b0;
        end else begin
            count      <= count_next;
            thresh_irq <= (thresh != '0) && (count_next >= CNT_WIDTH'(thresh));
        end
    end

endmodule

// File: rtl/uart_fifo_sched.sv
// UART FIFO scheduler: host write strobes, one-outstanding read sequencing and
// valid/ready hand-off of FIFO bytes to the transmitter.
module uart_fifo_sched
    import uart_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_C,
    parameter int unsigned CNT_WIDTH  = 9,
    parameter int unsigned RD_LATENCY = RD_LATENCY_C
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  HOST_WE,
    input  logic [DATA_WIDTH-1:0] HOST_DATA,
    output logic                  HOST_FULL,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF,
    input  logic [DATA_WIDTH-1:0] THRESH,
    output logic                  THRESH_IRQ,
    output logic [CNT_WIDTH-1:0]  COUNT,
    output logic                  FIFO_WRB,
    output logic [DATA_WIDTH-1:0] FIFO_DI,
    output logic                  FIFO_RDB,
    input  logic [DATA_WIDTH-1:0] FIFO_DO,
    input  logic                  FIFO_EMPTY,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY
);

    localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    rd_state_e        state;
    rd_state_e        state_next;
    logic [LAT_W-1:0] lat_cnt;
    logic             wr_accept_c;
    logic             rd_ok_c;
    logic             lat_done_c;
    logic             rd_issue_c;
    logic             capture_c;
    logic             tx_ack_c;

    uart_fifo_occ #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .THR_WIDTH  (DATA_WIDTH)
    ) u_occ (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .host_we     (HOST_WE),
        .fifo_full   (FIFO_FULL),
        .rd_issue    (rd_issue_c),
        .thresh      (THRESH),
        .count       (COUNT),
        .thresh_irq  (THRESH_IRQ),
        .host_full_c (HOST_FULL),
        .wr_accept_c (wr_accept_c)
    );

    // The FIFO empty flag lags writes, so the controller's own count must agree.
    assign rd_ok_c    = (COUNT != '0) & ~FIFO_EMPTY;
    assign lat_done_c = (lat_cnt == LAT_W'(RD_LATENCY - 1));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (rd_ok_c) state_next = WAIT;
            WAIT:    if (lat_done_c) state_next = HOLD;
            HOLD:    if (TX_READY) state_next = rd_ok_c ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_issue_c = 1'b0;
        capture_c  = 1'b0;
        tx_ack_c   = 1'b0;
        unique case (state)
            IDLE: rd_issue_c = rd_ok_c;
            WAIT: capture_c  = lat_done_c;
            HOLD: begin
                tx_ack_c   = TX_READY;
                rd_issue_c = TX_READY & rd_ok_c;
            end
            default: ;
        endcase
    end

    // Strobes, data capture, latency counter and sticky overflow.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            FIFO_WRB <= 1'b1;
            FIFO_DI  <= '0;
            FIFO_RDB <= 1'b1;
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            OVERFLOW <= 1'b0;
            lat_cnt  <= '0;
        end else begin
            FIFO_WRB <= ~wr_accept_c;
            if (wr_accept_c) begin
                FIFO_DI <= HOST_DATA;
            end
            FIFO_RDB <= ~rd_issue_c;
            if (HOST_WE && HOST_FULL) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end
            lat_cnt <= (state == WAIT && !lat_done_c) ? lat_cnt + LAT_W'(1) : '0;
            if (capture_c) begin
                TX_DATA  <= FIFO_DO;
                TX_VALID <= 1'b1;
            end else if (tx_ack_c) begin
                TX_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo_sched.sv
// Directed bench for uart_fifo_sched with a behavioural 256x8 FIFO (one-edge registered read).
module tb_uart_fifo_sched;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       HOST_WE;
    logic [7:0] HOST_DATA;
    logic       HOST_FULL;
    logic       OVERFLOW;
    logic       CLR_OVF;
    logic [7:0] THRESH;
    logic       THRESH_IRQ;
    logic [8:0] COUNT;
    logic       FIFO_WRB;
    logic [7:0] FIFO_DI;
    logic       FIFO_RDB;
    logic [7:0] FIFO_DO;
    logic       FIFO_EMPTY;
    logic       FIFO_FULL;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    uart_fifo_sched dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .HOST_WE    (HOST_WE),
        .HOST_DATA  (HOST_DATA),
        .HOST_FULL  (HOST_FULL),
        .OVERFLOW   (OVERFLOW),
        .CLR_OVF    (CLR_OVF),
        .THRESH     (THRESH),
        .THRESH_IRQ (THRESH_IRQ),
        .COUNT      (COUNT),
        .FIFO_WRB   (FIFO_WRB),
        .FIFO_DI    (FIFO_DI),
        .FIFO_RDB   (FIFO_RDB),
        .FIFO_DO    (FIFO_DO),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_FULL  (FIFO_FULL),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY)
    );

    // FIFO model, reset by the same RESET_N; the full flag is driven by the tests.
    logic [7:0] mem [0:255];
    logic [7:0] wptr;
    logic [7:0] rptr;
    logic [8:0] fcnt;
    logic       fifo_full_drv;

    assign FIFO_EMPTY = (fcnt == 9'd0);
    assign FIFO_FULL  = fifo_full_drv;

    always @(posedge CLK) begin
        if (!RESET_N) begin
            wptr    <= 8'd0;
            rptr    <= 8'd0;
            fcnt    <= 9'd0;
            FIFO_DO <= 8'd0;
        end else begin
            if (!FIFO_WRB) begin
                mem[wptr] <= FIFO_DI;
                wptr      <= wptr + 8'd1;
            end
            if (!FIFO_RDB) begin
                FIFO_DO <= mem[rptr];
                rptr    <= rptr + 8'd1;
            end
            fcnt <= fcnt + {8'd0, ~FIFO_WRB} - {8'd0, ~FIFO_RDB};
        end
    end

    // Strobe counters and record of every transmitter handshake.
    int         cyc       = 0;
    int         wr_pulses = 0;
    int         rd_pulses = 0;
    logic [7:0] rx_q [$];
    int         rx_t [$];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RESET_N) begin
            if (!FIFO_WRB) wr_pulses <= wr_pulses + 1;
            if (!FIFO_RDB) rd_pulses <= rd_pulses + 1;
            if (TX_VALID && TX_READY) begin
                rx_q.push_back(TX_DATA);
                rx_t.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; HOST_WE = 1'b0; CLR_OVF = 1'b0; TX_READY = 1'b0;
        THRESH = 8'd0; fifo_full_drv = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic drain(input int max_cyc);
        int quiet = 0;
        int i = 0;
        TX_READY = 1'b1;
        while (quiet < 4 && i < max_cyc) begin
            tick();
            i++;
            if (COUNT == 9'd0 && !TX_VALID && FIFO_RDB) quiet++;
            else quiet = 0;
        end
        TX_READY = 1'b0;
        n_checks++;
        if (quiet < 4) begin
            n_fail++;
            $display("FAIL drain_timeout: COUNT=%0d TX_VALID=%b after %0d cycles, required idle", COUNT, TX_VALID, i);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; HOST_WE = 1'b1; HOST_DATA = 8'hFF; CLR_OVF = 1'b0;
        THRESH = 8'd1; TX_READY = 1'b1; fifo_full_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (FIFO_WRB !== 1'b1) begin n_fail++; $display("FAIL reset_wrb: got %b want 1", FIFO_WRB); end
            n_checks++;
            if (COUNT !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", COUNT); end
            n_checks++;
            if (TX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_txvalid: got %b want 0", TX_VALID); end
        end
        n_checks++;
        if ({FIFO_RDB, OVERFLOW, THRESH_IRQ} !== 3'b100)
            begin n_fail++; $display("FAIL reset_flags: rdb/ovf/irq got %b want 100", {FIFO_RDB, OVERFLOW, THRESH_IRQ}); end
        n_checks++;
        if ({FIFO_DI, TX_DATA} !== 16'h0000)
            begin n_fail++; $display("FAIL reset_data: di/tx got %h want 0000", {FIFO_DI, TX_DATA}); end
        HOST_WE = 1'b0; THRESH = 8'd0; TX_READY = 1'b0;
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        int rd0;
        int base;
        do_reset();
        rd0 = rd_pulses; base = rx_q.size();
        TX_READY = 1'b1; HOST_DATA = 8'hA5; HOST_WE = 1'b1;
        tick();
        HOST_WE = 1'b0;
        n_checks++;
        if ({FIFO_WRB, FIFO_DI} !== {1'b0, 8'hA5}) begin n_fail++; $display("FAIL single_wr: wrb/di got %b/%h want 0/a5", FIFO_WRB, FIFO_DI); end
        n_checks++;
        if (COUNT !== 9'd1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", COUNT); end
        tick();
        n_checks++;
        if ({FIFO_WRB, FIFO_RDB} !== 2'b11) begin n_fail++; $display("FAIL single_strobes_idle: wrb/rdb got %b want 11", {FIFO_WRB, FIFO_RDB}); end
        tick();
        n_checks++;
        if ({FIFO_RDB, COUNT} !== {1'b0, 9'd0}) begin n_fail++; $display("FAIL single_rd_issue: rdb=%b count=%0d want 0/0", FIFO_RDB, COUNT); end
        tick();
        n_checks++;
        if ({FIFO_RDB, TX_VALID} !== 2'b10) begin n_fail++; $display("FAIL single_wait: rdb/valid got %b want 10", {FIFO_RDB, TX_VALID}); end
        tick();
        n_checks++;
        if ({TX_VALID, TX_DATA} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL single_tx: valid/data got %b/%h want 1/a5", TX_VALID, TX_DATA); end
        tick();
        TX_READY = 1'b0;
        n_checks++;
        if ({TX_VALID, COUNT} !== {1'b0, 9'd0}) begin n_fail++; $display("FAIL single_done: valid=%b count=%0d want 0/0", TX_VALID, COUNT); end
        n_checks++;
        if (rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL single_rd_pulses: got %0d want 1", rd_pulses - rd0); end
        n_checks++;
        if (rx_q.size() != base + 1 || rx_q[rx_q.size()-1] !== 8'hA5)
            begin n_fail++; $display("FAIL single_handshake: %0d bytes, want 1 byte a5", rx_q.size() - base); end
    endtask

    task automatic test_back_pressure();
        int rd0;
        int base;
        int i;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        do_reset();
        rd0 = rd_pulses;
        for (int k = 0; k < 3; k++) begin
            HOST_WE = 1'b1; HOST_DATA = exp_b[k];
            tick();
        end
        HOST_WE = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if ({TX_VALID, TX_DATA} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL bp_hold: valid/data got %b/%h want 1/11", TX_VALID, TX_DATA); end
        n_checks++;
        if (COUNT !== 9'd2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", COUNT); end
        n_checks++;
        if (rd_pulses - rd0 != 1) begin n_fail++; $display("FAIL bp_one_read: got %0d reads want 1", rd_pulses - rd0); end
        base = rx_q.size();
        TX_READY = 1'b1;
        i = 0;
        while (rx_q.size() < base + 3 && i < 30) begin tick(); i++; end
        TX_READY = 1'b0;
        n_checks++;
        if (rx_q.size() != base + 3) begin
            n_fail++; $display("FAIL bp_delivered: got %0d bytes want 3", rx_q.size() - base);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rx_q[base+k] !== exp_b[k]) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", k, rx_q[base+k], exp_b[k]); end
            end
            n_checks++;
            if (rx_t[base+1] - rx_t[base] != 3 || rx_t[base+2] - rx_t[base+1] != 3)
                begin n_fail++; $display("FAIL bp_spacing: got %0d,%0d cycles want 3,3", rx_t[base+1] - rx_t[base], rx_t[base+2] - rx_t[base+1]); end
        end
        drain(50);
    endtask

    task automatic test_simultaneous();
        int base;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            HOST_WE = 1'b1; HOST_DATA = 8'(8'h40 + k);
            tick();
        end
        HOST_WE = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        n_checks++;
        if ({TX_VALID, COUNT} !== {1'b1, 9'd5}) begin n_fail++; $display("FAIL sim_setup: valid=%b count=%0d want 1/5", TX_VALID, COUNT); end
        base = rx_q.size();
        HOST_WE = 1'b1; HOST_DATA = 8'h50; TX_READY = 1'b1;
        tick();
        HOST_WE = 1'b0; TX_READY = 1'b0;
        n_checks++;
        if (COUNT !== 9'd5) begin n_fail++; $display("FAIL sim_count: got %0d want 5", COUNT); end
        n_checks++;
        if ({FIFO_WRB, FIFO_RDB} !== 2'b00) begin n_fail++; $display("FAIL sim_strobes: wrb/rdb got %b want 00", {FIFO_WRB, FIFO_RDB}); end
        drain(100);
        n_checks++;
        if (rx_q.size() != base + 7 || rx_q[rx_q.size()-1] !== 8'h50)
            begin n_fail++; $display("FAIL sim_drain: got %0d bytes want 7 ending in 50", rx_q.size() - base); end
    endtask

    task automatic test_full_overflow();
        int wr0;
        int base;
        do_reset();
        wr0 = wr_pulses; base = rx_q.size();
        for (int k = 0; k < 256; k++) begin
            HOST_WE = 1'b1; HOST_DATA = 8'(k);
            tick();
        end
        HOST_WE = 1'b0;
        tick();
        n_checks++;
        if ({COUNT, HOST_FULL} !== {9'd255, 1'b0}) begin n_fail++; $display("FAIL full_255: count=%0d host_full=%b want 255/0", COUNT, HOST_FULL); end
        n_checks++;
        if (wr_pulses - wr0 != 256) begin n_fail++; $display("FAIL full_wr_pulses: got %0d want 256", wr_pulses - wr0); end
        fifo_full_drv = 1'b1;
        #1;
        n_checks++;
        if (HOST_FULL !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", HOST_FULL); end
        HOST_WE = 1'b1; HOST_DATA = 8'hDD;
        tick();
        HOST_WE = 1'b0;
        n_checks++;
        if ({FIFO_WRB, OVERFLOW, COUNT} !== {1'b1, 1'b1, 9'd255})
            begin n_fail++; $display("FAIL ovf_set: wrb=%b ovf=%b count=%0d want 1/1/255", FIFO_WRB, OVERFLOW, COUNT); end
        tick();
        n_checks++;
        if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); end
        CLR_OVF = 1'b1; HOST_WE = 1'b1;
        tick();
        HOST_WE = 1'b0;
        n_checks++;
        if (OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", OVERFLOW); end
        tick();
        CLR_OVF = 1'b0;
        n_checks++;
        if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", OVERFLOW); end
        fifo_full_drv = 1'b0;
        HOST_WE = 1'b1; HOST_DATA = 8'hEE;
        tick();
        HOST_WE = 1'b0;
        n_checks++;
        if ({COUNT, HOST_FULL, OVERFLOW} !== {9'd256, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL full_256: count=%0d host_full=%b ovf=%b want 256/1/0", COUNT, HOST_FULL, OVERFLOW); end
        HOST_WE = 1'b1; HOST_DATA = 8'hCC;
        tick();
        HOST_WE = 1'b0;
        n_checks++;
        if ({FIFO_WRB, OVERFLOW, COUNT} !== {1'b1, 1'b1, 9'd256})
            begin n_fail++; $display("FAIL full_count_block: wrb=%b ovf=%b count=%0d want 1/1/256", FIFO_WRB, OVERFLOW, COUNT); end
        drain(1200);
        n_checks++;
        if (rx_q.size() != base + 257 || rx_q[base] !== 8'h00 || rx_q[rx_q.size()-1] !== 8'hEE)
            begin n_fail++; $display("FAIL full_drain: got %0d bytes want 257 from 00 to ee", rx_q.size() - base); end
    endtask

    task automatic test_threshold();
        int exp_cnt [4];
        exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 2; exp_cnt[3] = 3;
        do_reset();
        THRESH = 8'd4;
        for (int k = 0; k < 4; k++) begin
            HOST_WE = 1'b1; HOST_DATA = 8'(k);
            tick();
            n_checks++;
            if ({COUNT, THRESH_IRQ} !== {9'(exp_cnt[k]), 1'b0})
                begin n_fail++; $display("FAIL thr_below%0d: count=%0d irq=%b want %0d/0", k, COUNT, THRESH_IRQ, exp_cnt[k]); end
        end
        tick();
        HOST_WE = 1'b0;
        n_checks++;
        if ({COUNT, THRESH_IRQ, TX_VALID} !== {9'd4, 1'b1, 1'b1})
            begin n_fail++; $display("FAIL thr_rise: count=%0d irq=%b valid=%b want 4/1/1", COUNT, THRESH_IRQ, TX_VALID); end
        TX_READY = 1'b1;
        tick();
        TX_READY = 1'b0;
        n_checks++;
        if ({COUNT, THRESH_IRQ} !== {9'd3, 1'b0}) begin n_fail++; $display("FAIL thr_fall: count=%0d irq=%b want 3/0", COUNT, THRESH_IRQ); end
        THRESH = 8'd0;
        HOST_WE = 1'b1; HOST_DATA = 8'h77;
        tick();
        HOST_WE = 1'b0;
        n_checks++;
        if ({COUNT, THRESH_IRQ} !== {9'd4, 1'b0}) begin n_fail++; $display("FAIL thr_zero: count=%0d irq=%b want 4/0", COUNT, THRESH_IRQ); end
        drain(100);
    endtask

    task automatic test_reset_midread();
        do_reset();
        HOST_WE = 1'b1; HOST_DATA = 8'h3C;
        tick();
        HOST_WE = 1'b0;
        tick();
        tick();
        n_checks++;
        if (FIFO_RDB !== 1'b0) begin n_fail++; $display("FAIL mid_rd_issue: rdb got %b want 0", FIFO_RDB); end
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_checks++;
        if ({TX_VALID, COUNT, TX_DATA} !== {1'b0, 9'd0, 8'h00})
            begin n_fail++; $display("FAIL mid_discard: valid=%b count=%0d data=%h want 0/0/00", TX_VALID, COUNT, TX_DATA); end
    endtask

    initial begin
        RESET_N = 1'b0; HOST_WE = 1'b0; HOST_DATA = 8'h00; CLR_OVF = 1'b0;
        THRESH = 8'd0; TX_READY = 1'b0; fifo_full_drv = 1'b0;
        test_reset();
        test_single_byte();
        test_back_pressure();
        test_simultaneous();
        test_full_overflow();
        test_threshold();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
